// File: rtl/x_top_pkg.sv
// Shared constants and state types for the UART-to-bus bridge.
// Both FSM state types are bundled into one debug struct exported at the top.
package x_top_pkg;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } bridge_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    bridge_state_e bridge;
    rx_state_e     rx;
  } dbg_state_t;

endpackage

// File: rtl/x_top_uart.sv
// 8N1 UART: 2-flop synchronised receiver with mid-bit sampling, and a transmitter
// whose ready rises in the last stop-bit cycle so queued bytes go out gap-free.
module x_top_uart
  import x_top_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx,
  output rx_state_e  o_rx_state
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  logic [1:0]    rx_sync;
  logic          rx_s;
  logic          rx_prev;
  rx_state_e     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;

  assign rx_s       = rx_sync[1];
  assign o_rx_state = rx_state;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rx_sync    <= 2'b11;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
    end else begin
      rx_sync    <= {rx_sync[0], i_rx};
      rx_prev    <= rx_s;
      o_rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (rx_cnt == HALF_M1) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s) begin
              o_rx_valid <= 1'b1;
              o_rx_data  <= rx_sh;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;

  // Handshake: a byte is taken in any cycle with i_tx_valid & o_tx_ready; its
  // start bit appears on o_tx the following cycle.
  assign o_tx_ready = !tx_busy || (tx_cnt == DIV_M1 && tx_bit == 4'd9);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
      o_tx    <= 1'b1;
    end else if (i_tx_valid && o_tx_ready) begin
      tx_busy <= 1'b1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= {1'b1, i_tx_data};
      o_tx    <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == DIV_M1) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          tx_bit <= tx_bit + 1'b1;
          o_tx   <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[8:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/x_top_uart_bridge.sv
// Host-facing bridge: parses 'W'/'R' frames from the UART, masters one bus
// transfer per frame and answers with an ACK byte or four read-data bytes.
module x_top_uart_bridge
  import x_top_pkg::*;
#(
  parameter int p_clk_hz  = 1200000,
  parameter int p_baud    = 115200,
  parameter int p_timeout = 100000
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_valid,
  input  logic        i_accept,
  output logic        o_rnw,
  output logic [31:0] o_addr,
  output logic [31:0] o_data,
  input  logic [31:0] i_data,
  output dbg_state_t  o_dbg
);

  localparam int DIV = p_clk_hz / p_baud;
  localparam int TW  = $clog2(p_timeout + 1);
  localparam logic [TW-1:0] TO_M1 = TW'(p_timeout - 1);

  bridge_state_e state;
  rx_state_e     rx_state;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] to_cnt;
  logic [23:0]   resp_sh;
  logic [1:0]    resp_left;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          tx_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;

  // The first reply byte is handed over in the handshake cycle itself; the
  // transmitter is always idle in BUS because RESP drains it before IDLE.
  assign tx_valid = (state == ST_BUS && i_accept) || (state == ST_RESP && resp_left != 2'd0);
  assign tx_data  = (state == ST_BUS) ? (o_rnw ? i_data[7:0] : ACK) : resp_sh[7:0];
  assign o_dbg    = '{bridge: state, rx: rx_state};

  x_top_uart #(.DIV(DIV)) u_uart (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_rx       (i_rx),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .i_tx_data  (tx_data),
    .i_tx_valid (tx_valid),
    .o_tx_ready (tx_ready),
    .o_tx       (o_tx),
    .o_rx_state (rx_state)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= ST_IDLE;
      o_valid   <= 1'b0;
      o_rnw     <= 1'b1;
      o_addr    <= '0;
      o_data    <= '0;
      byte_cnt  <= '0;
      to_cnt    <= '0;
      resp_sh   <= '0;
      resp_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          byte_cnt <= '0;
          to_cnt   <= '0;
          if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
            o_rnw <= (rx_data == CMD_RD);
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // A byte arriving on the timeout cycle takes priority.
          if (rx_valid) begin
            to_cnt   <= '0;
            o_addr   <= {rx_data, o_addr[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (o_rnw) begin
                state   <= ST_BUS;
                o_valid <= 1'b1;
              end else begin
                state <= ST_DATA;
              end
            end
          end else if (to_cnt == TO_M1) begin
            state <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            to_cnt   <= '0;
            o_data   <= {rx_data, o_data[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state   <= ST_BUS;
              o_valid <= 1'b1;
            end
          end else if (to_cnt == TO_M1) begin
            state <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_BUS: begin
          if (i_accept) begin
            o_valid   <= 1'b0;
            state     <= ST_RESP;
            resp_sh   <= i_data[31:8];
            resp_left <= o_rnw ? 2'd3 : 2'd0;
          end
        end
        ST_RESP: begin
          if (tx_ready) begin
            if (resp_left != 2'd0) begin
              resp_sh   <= {8'h00, resp_sh[23:8]};
              resp_left <= resp_left - 2'd1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x_top_uart_bridge.sv
// Bench for x_top_uart_bridge: serial frame driver, frame-level reference model,
// scoreboard queues checked by independent bus and UART-TX monitors.
module tb_x_top_uart_bridge;
  import x_top_pkg::*;

  localparam int CLK_HZ  = 1200000;
  localparam int BAUD    = 115200;
  localparam int TIMEOUT = 2000;
  localparam int DIV     = CLK_HZ / BAUD;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic        o_valid;
  logic        accept = 1'b0;
  logic        rnw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rd_value = 32'h0;
  dbg_state_t  dbg;

  typedef struct packed {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  len;
  } bus_exp_t;

  bus_exp_t   bus_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] frame_q[$];

  int n_pass = 0;
  int n_total = 0;
  bit accept_tied = 1'b1;
  int accept_delay = 0;
  int wait_cnt = 0;

  x_top_uart_bridge #(
    .p_clk_hz  (CLK_HZ),
    .p_baud    (BAUD),
    .p_timeout (TIMEOUT)
  ) dut (
    .i_clk    (clk),
    .i_nrst   (nrst),
    .i_rx     (rx),
    .o_tx     (tx),
    .o_valid  (o_valid),
    .i_accept (accept),
    .o_rnw    (rnw),
    .o_addr   (addr),
    .o_data   (wdata),
    .i_data   (rd_value),
    .o_dbg    (dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] exp_len();
    return accept_tied ? 8'd1 : 8'(accept_delay + 1);
  endfunction

  // Frame-level reference: collects bytes after a command, emits one bus op
  // and the reply bytes once the frame is complete.
  task automatic model_byte(input logic [7:0] b);
    bus_exp_t e;
    if (frame_q.size() == 0) begin
      if (b == 8'h57 || b == 8'h52) frame_q.push_back(b);
    end else begin
      frame_q.push_back(b);
      if (frame_q[0] == 8'h57 && frame_q.size() == 9) begin
        e.rnw  = 1'b0;
        e.addr = {frame_q[4], frame_q[3], frame_q[2], frame_q[1]};
        e.data = {frame_q[8], frame_q[7], frame_q[6], frame_q[5]};
        e.len  = exp_len();
        bus_q.push_back(e);
        exp_q.push_back(8'h06);
        frame_q.delete();
      end else if (frame_q[0] == 8'h52 && frame_q.size() == 5) begin
        e.rnw  = 1'b1;
        e.addr = {frame_q[4], frame_q[3], frame_q[2], frame_q[1]};
        e.data = rd_value;
        e.len  = exp_len();
        bus_q.push_back(e);
        for (int i = 0; i < 4; i++) exp_q.push_back(rd_value[8*i +: 8]);
        frame_q.delete();
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic hold_bit();
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    if (good) model_byte(b);
    rx = 1'b0;
    hold_bit();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold_bit();
    end
    rx = good;
    hold_bit();
    rx = 1'b1;
    if (!good) hold_bit();
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((bus_q.size() != 0 || exp_q.size() != 0 || dbg.bridge != ST_IDLE) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check({"drain_", name}, 64'(n < 5000), 64'd1);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    bus_q.delete();
    exp_q.delete();
    frame_q.delete();
  endtask

  // ---------------- bus slave: accept policy ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (accept_tied) begin
        accept = 1'b1;
      end else if (o_valid && nrst) begin
        accept = (wait_cnt == accept_delay);
        wait_cnt++;
      end else begin
        accept = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // ---------------- bus monitor ----------------
  initial begin
    int          vcnt;
    bit          moved;
    logic        v_rnw;
    logic [31:0] v_addr;
    logic [31:0] v_data;
    bus_exp_t    e;
    vcnt = 0;
    moved = 1'b0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        vcnt = 0;
      end else if (o_valid) begin
        if (vcnt == 0) begin
          v_rnw  = rnw;
          v_addr = addr;
          v_data = wdata;
          moved  = 1'b0;
        end else if (rnw !== v_rnw || addr !== v_addr || wdata !== v_data) begin
          moved = 1'b1;
        end
        vcnt++;
        if (accept) begin
          if (bus_q.size() == 0) begin
            n_total++;
            $display("FAIL bus_unexpected: got request rnw=%0b addr=%0h, expected none", rnw, addr);
          end else begin
            e = bus_q.pop_front();
            check("bus_rnw", 64'(rnw), 64'(e.rnw));
            check("bus_addr", 64'(addr), 64'(e.addr));
            if (!e.rnw) check("bus_wdata", 64'(wdata), 64'(e.data));
            check("bus_len", 64'(vcnt), 64'(e.len));
            check("bus_stable", 64'(moved), 64'd0);
          end
          vcnt = 0;
        end
      end
    end
  end

  // ---------------- UART TX monitor ----------------
  initial begin
    logic [7:0] b;
    logic       start_b;
    logic       stop_b;
    bit         aborted;
    forever begin
      @(negedge tx);
      aborted = !nrst;
      for (int i = 0; i < DIV / 2; i++) begin
        @(negedge clk);
        if (!nrst) aborted = 1'b1;
      end
      start_b = tx;
      for (int k = 0; k < 8; k++) begin
        for (int i = 0; i < DIV; i++) begin
          @(negedge clk);
          if (!nrst) aborted = 1'b1;
        end
        b[k] = tx;
      end
      for (int i = 0; i < DIV; i++) begin
        @(negedge clk);
        if (!nrst) aborted = 1'b1;
      end
      stop_b = tx;
      if (!aborted) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL tx_unexpected: got byte %0h, expected none", b);
        end else begin
          check("tx_start", 64'(start_b), 64'd0);
          check("tx_byte", 64'(b), 64'(exp_q.pop_front()));
          check("tx_stop", 64'(stop_b), 64'd1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int          n;
    logic [7:0]  g;
    logic [31:0] ra;
    logic [31:0] rd;

    nrst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_rnw", 64'(rnw), 64'd1);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_data", 64'(wdata), 64'd0);
    check("rst_state", 64'(dbg.bridge), 64'(ST_IDLE));
    nrst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // write with accept tied high
    accept_tied = 1'b1;
    send_write(32'h0000_0010, 32'hDEAD_BEEF);
    wait_drain("write");

    // read with accept delayed 5 cycles
    accept_tied = 1'b0;
    accept_delay = 5;
    rd_value = 32'h1234_5678;
    send_read(32'h0000_0020);
    wait_drain("read");

    // non-command byte in IDLE is dropped
    accept_tied = 1'b1;
    send_byte(8'h41, 1'b1);
    rd_value = 32'hA1B2_C3D4;
    send_read(32'h0000_1234);
    wait_drain("garbage");

    // partial write abandoned by the timeout
    send_byte(8'h57, 1'b1);
    send_byte(8'h99, 1'b1);
    send_byte(8'h88, 1'b1);
    repeat (TIMEOUT + 10) @(posedge clk);
    #1;
    check("timeout_idle", 64'(dbg.bridge), 64'(ST_IDLE));
    frame_q.delete();
    rd_value = 32'h0BAD_F00D;
    send_read(32'hCAFE_0040);
    wait_drain("timeout");

    // framing error on an address byte
    rd_value = 32'h7766_5544;
    send_byte(8'h52, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("badstop_hold", 64'(dbg.bridge), 64'(ST_ADDR));
    send_byte(8'h22, 1'b1);
    wait_drain("badstop");

    // reset while a bus request is pending
    accept_tied = 1'b0;
    accept_delay = 100000;
    send_read(32'h0000_0abc);
    n = 0;
    while (!o_valid && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rstbus_valid_seen", 64'(o_valid), 64'd1);
    nrst = 1'b0;
    #1;
    check("rstbus_valid", 64'(o_valid), 64'd0);
    check("rstbus_tx", 64'(tx), 64'd1);
    check("rstbus_rnw", 64'(rnw), 64'd1);
    flush_model();
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    accept_tied = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send_write(32'h0000_0100, 32'h0102_0304);
    wait_drain("after_rst_bus");

    // reset in the middle of a TX byte
    rd_value = 32'h5A5A_5A00;
    send_read(32'h0000_0200);
    n = 0;
    while (tx && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (15) @(posedge clk);
    #1;
    check("rsttx_mid_low", 64'(tx), 64'd0);
    nrst = 1'b0;
    #1;
    check("rsttx_tx", 64'(tx), 64'd1);
    check("rsttx_valid", 64'(o_valid), 64'd0);
    flush_model();
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    rd_value = 32'hFEED_0001;
    send_read(32'h0000_0300);
    wait_drain("after_rst_tx");

    // randomized frames with random accept behaviour and stray bytes
    for (int it = 0; it < 10; it++) begin
      accept_tied = 1'($urandom_range(0, 1));
      accept_delay = $urandom_range(0, 7);
      if ($urandom_range(0, 2) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'h57 || g == 8'h52) g = 8'h00;
        send_byte(g, 1'b1);
      end
      ra = $urandom;
      rd = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        send_write(ra, rd);
      end else begin
        rd_value = rd;
        send_read(ra);
      end
      wait_drain("random");
    end

    check("final_bus_q", 64'(bus_q.size()), 64'd0);
    check("final_tx_q", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
